// File: rtl/loader_pkg.sv
// Shared definitions for the serial program loader.
//   ACK_BYTE / NAK_BYTE   : reply bytes sent on usb_tx after each frame
//   DEFAULT_SYNC_BYTE     : default frame start byte
//   loader_state_t        : loader FSM encoding (WAIT_SYNC / LOAD / REPLY)
//   rx_state_t, tx_state_t: UART receiver / transmitter FSM encodings
package loader_pkg;

   localparam logic [7:0] ACK_BYTE          = 8'h06;
   localparam logic [7:0] NAK_BYTE          = 8'h15;
   localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

   typedef enum logic [1:0] {WAIT_SYNC, LOAD, REPLY} loader_state_t;
   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
   typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

endpackage

// File: rtl/uart_rx_8n1.sv
// 8N1 UART receiver with a two-flop input synchroniser.
//   clk, rst_n : system clock, asynchronous active-low reset
//   rx         : serial line, idle high, asynchronous to clk
//   rx_data    : received byte, valid while rx_valid is high
//   rx_valid   : one-clk pulse for a byte whose stop bit was high
//   rx_ferr    : one-clk pulse for a byte whose stop bit was low (byte dropped)
module uart_rx_8n1
   import loader_pkg::*;
#(
   parameter int CLKS_PER_BIT = 100
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rx,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       rx_ferr
);

   localparam int TW = $clog2(CLKS_PER_BIT);
   localparam logic [TW-1:0] BIT_LAST  = TW'(CLKS_PER_BIT - 1);
   localparam logic [TW-1:0] HALF_LAST = TW'(CLKS_PER_BIT / 2 - 1);

   logic          rx_meta;
   logic          rx_sync;
   logic          rx_prev;
   rx_state_t     state;
   logic [TW-1:0] timer;
   logic [2:0]    bit_idx;
   logic [7:0]    shreg;

   // Two-flop synchroniser plus one delayed copy for falling-edge detection.
   // All reset high so that reset never looks like a start bit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_meta <= 1'b1;
         rx_sync <= 1'b1;
         rx_prev <= 1'b1;
      end else begin
         rx_meta <= rx;
         rx_sync <= rx_meta;
         rx_prev <= rx_sync;
      end
   end

   // Receiver FSM. The start bit is re-checked half a bit after the edge so
   // short low glitches are rejected; every later sample lands on a bit centre.
   // Leaving RX_STOP right at the stop-bit sample rearms for the next edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= RX_IDLE;
         timer    <= '0;
         bit_idx  <= '0;
         shreg    <= '0;
         rx_data  <= '0;
         rx_valid <= 1'b0;
         rx_ferr  <= 1'b0;
      end else begin
         rx_valid <= 1'b0;
         rx_ferr  <= 1'b0;
         case (state)
            RX_IDLE: begin
               timer <= '0;
               if (!rx_sync && rx_prev) state <= RX_START;
            end
            RX_START: begin
               if (timer == HALF_LAST) begin
                  timer   <= '0;
                  bit_idx <= '0;
                  state   <= rx_sync ? RX_IDLE : RX_DATA;
               end else begin
                  timer <= timer + TW'(1);
               end
            end
            RX_DATA: begin
               if (timer == BIT_LAST) begin
                  timer   <= '0;
                  shreg   <= {rx_sync, shreg[7:1]};
                  bit_idx <= bit_idx + 3'd1;
                  if (bit_idx == 3'd7) state <= RX_STOP;
               end else begin
                  timer <= timer + TW'(1);
               end
            end
            RX_STOP: begin
               if (timer == BIT_LAST) begin
                  timer <= '0;
                  state <= RX_IDLE;
                  if (rx_sync) begin
                     rx_valid <= 1'b1;
                     rx_data  <= shreg;
                  end else begin
                     rx_ferr <= 1'b1;
                  end
               end else begin
                  timer <= timer + TW'(1);
               end
            end
            default: state <= RX_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/uart_program_loader.sv
// Serial program loader: receives SYNC + RAM_DEPTH bytes over UART, writes
// them to the RAM write port and answers ACK or NAK, holding the CPU in reset
// for the duration of the frame.
//   clk, rst_n : system clock, asynchronous active-low reset
//   usb_rx     : UART receive line (idle high)
//   usb_tx     : UART transmit line (idle high), carries ACK/NAK
//   prog_addr  : RAM write address, prog_data : RAM write data
//   prog_we    : one-clk RAM write strobe
//   cpu_hold   : high while a frame is in progress
//   load_done  : sticky, last frame completed; cleared by next SYNC
//   frame_err  : one-clk pulse on stop-bit error or inter-byte timeout
module uart_program_loader
   import loader_pkg::*;
#(
   parameter int          CLK_HZ         = 100_000_000,
   parameter int          BAUD           = 1_000_000,
   parameter int          RAM_DEPTH      = 16,
   parameter int          ADDR_W         = 4,
   parameter logic [7:0]  SYNC_BYTE      = DEFAULT_SYNC_BYTE,
   parameter int          TIMEOUT_CYCLES = 10_000_000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              usb_rx,
   output logic              usb_tx,
   output logic [ADDR_W-1:0] prog_addr,
   output logic [7:0]        prog_data,
   output logic              prog_we,
   output logic              cpu_hold,
   output logic              load_done,
   output logic              frame_err
);

   localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
   localparam int TW = $clog2(CLKS_PER_BIT);
   localparam int IW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0]     BIT_LAST  = TW'(CLKS_PER_BIT - 1);
   localparam logic [IW-1:0]     IDLE_MAX  = IW'(TIMEOUT_CYCLES);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(RAM_DEPTH - 1);

   logic [7:0]        rx_data;
   logic              rx_valid;
   logic              rx_ferr;

   loader_state_t     state;
   logic [ADDR_W-1:0] addr;
   logic [IW-1:0]     idle_cnt;
   logic              tx_start;
   logic [7:0]        tx_byte;
   logic              tx_done;

   tx_state_t         tx_state;
   logic [TW-1:0]     tx_timer;
   logic [2:0]        tx_bit;
   logic [7:0]        tx_shreg;

   uart_rx_8n1 #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
      .clk      (clk),
      .rst_n    (rst_n),
      .rx       (usb_rx),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .rx_ferr  (rx_ferr)
   );

   // Loader FSM. Receiver framing errors always surface on frame_err, but
   // only abort a frame while in LOAD. Bytes seen during REPLY are dropped.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= WAIT_SYNC;
         addr      <= '0;
         idle_cnt  <= '0;
         prog_addr <= '0;
         prog_data <= '0;
         prog_we   <= 1'b0;
         cpu_hold  <= 1'b0;
         load_done <= 1'b0;
         frame_err <= 1'b0;
         tx_start  <= 1'b0;
         tx_byte   <= '0;
      end else begin
         prog_we   <= 1'b0;
         tx_start  <= 1'b0;
         frame_err <= rx_ferr;
         case (state)
            WAIT_SYNC: begin
               if (rx_valid && rx_data == SYNC_BYTE) begin
                  state     <= LOAD;
                  cpu_hold  <= 1'b1;
                  load_done <= 1'b0;
                  addr      <= '0;
                  idle_cnt  <= '0;
               end
            end
            LOAD: begin
               if (rx_valid) begin
                  prog_we   <= 1'b1;
                  prog_addr <= addr;
                  prog_data <= rx_data;
                  idle_cnt  <= '0;
                  if (addr == LAST_ADDR) begin
                     tx_byte   <= ACK_BYTE;
                     tx_start  <= 1'b1;
                     load_done <= 1'b1;
                     state     <= REPLY;
                  end else begin
                     addr <= addr + ADDR_W'(1);
                  end
               end else if (rx_ferr || idle_cnt == IDLE_MAX) begin
                  frame_err <= 1'b1;
                  tx_byte   <= NAK_BYTE;
                  tx_start  <= 1'b1;
                  state     <= REPLY;
               end else begin
                  idle_cnt <= idle_cnt + IW'(1);
               end
            end
            REPLY: begin
               if (tx_done) begin
                  cpu_hold <= 1'b0;
                  state    <= WAIT_SYNC;
               end
            end
            default: state <= WAIT_SYNC;
         endcase
      end
   end

   // Transmitter FSM. usb_tx is registered and changes only at bit
   // boundaries, so every bit is exactly CLKS_PER_BIT clocks wide. tx_done
   // pulses on the edge where the stop bit ends.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_state <= TX_IDLE;
         tx_timer <= '0;
         tx_bit   <= '0;
         tx_shreg <= '0;
         tx_done  <= 1'b0;
         usb_tx   <= 1'b1;
      end else begin
         tx_done <= 1'b0;
         case (tx_state)
            TX_IDLE: begin
               tx_timer <= '0;
               if (tx_start) begin
                  tx_shreg <= tx_byte;
                  usb_tx   <= 1'b0;
                  tx_state <= TX_START;
               end
            end
            TX_START: begin
               if (tx_timer == BIT_LAST) begin
                  tx_timer <= '0;
                  tx_bit   <= '0;
                  usb_tx   <= tx_shreg[0];
                  tx_shreg <= {1'b0, tx_shreg[7:1]};
                  tx_state <= TX_DATA;
               end else begin
                  tx_timer <= tx_timer + TW'(1);
               end
            end
            TX_DATA: begin
               if (tx_timer == BIT_LAST) begin
                  tx_timer <= '0;
                  if (tx_bit == 3'd7) begin
                     usb_tx   <= 1'b1;
                     tx_state <= TX_STOP;
                  end else begin
                     usb_tx   <= tx_shreg[0];
                     tx_shreg <= {1'b0, tx_shreg[7:1]};
                     tx_bit   <= tx_bit + 3'd1;
                  end
               end else begin
                  tx_timer <= tx_timer + TW'(1);
               end
            end
            TX_STOP: begin
               if (tx_timer == BIT_LAST) begin
                  tx_timer <= '0;
                  tx_done  <= 1'b1;
                  tx_state <= TX_IDLE;
               end else begin
                  tx_timer <= tx_timer + TW'(1);
               end
            end
            default: tx_state <= TX_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_program_loader.sv
// Directed bench for uart_program_loader: 16 clocks per bit, 2000-clock
// inter-byte timeout. Monitors log RAM writes, frame_err pulses, receiver
// bytes and decode usb_tx; the main sequence compares them to fixed values.
`timescale 1ns/1ps
module tb_uart_program_loader;

   logic       clk;
   logic       rst_n;
   logic       usb_rx;
   logic       usb_tx;
   logic [3:0] prog_addr;
   logic [7:0] prog_data;
   logic       prog_we;
   logic       cpu_hold;
   logic       load_done;
   logic       frame_err;

   int compared;
   int mismatched;

   logic [3:0] wr_addr [0:255];
   logic [7:0] wr_data [0:255];
   int         wr_count;
   int         ferr_count;
   int         rxv_count;
   int         tx_count;
   logic [7:0] tx_last;
   logic [7:0] tx_shift;
   logic       tx_stop;
   logic [7:0] frame_data [0:15];

   uart_program_loader #(
      .CLK_HZ         (16_000_000),
      .BAUD           (1_000_000),
      .RAM_DEPTH      (16),
      .ADDR_W         (4),
      .SYNC_BYTE      (8'hA5),
      .TIMEOUT_CYCLES (2000)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .usb_rx    (usb_rx),
      .usb_tx    (usb_tx),
      .prog_addr (prog_addr),
      .prog_data (prog_data),
      .prog_we   (prog_we),
      .cpu_hold  (cpu_hold),
      .load_done (load_done),
      .frame_err (frame_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Scoreboard of RAM writes and pulse counters, sampled on the falling edge.
   initial begin
      wr_count   = 0;
      ferr_count = 0;
      rxv_count  = 0;
      forever begin
         @(negedge clk);
         if (prog_we === 1'b1 && wr_count < 256) begin
            wr_addr[wr_count] = prog_addr;
            wr_data[wr_count] = prog_data;
            wr_count++;
         end
         if (frame_err === 1'b1) ferr_count++;
         if (dut.u_rx.rx_valid === 1'b1) rxv_count++;
      end
   end

   // usb_tx decoder: sample at bit centres, 16 clocks per bit.
   initial begin
      tx_count = 0;
      tx_last  = '0;
      tx_shift = '0;
      tx_stop  = 1'b0;
      forever begin
         @(negedge clk);
         if (rst_n === 1'b1 && usb_tx === 1'b0) begin
            repeat (8) @(negedge clk);
            for (int b = 0; b < 8; b++) begin
               repeat (16) @(negedge clk);
               tx_shift[b] = usb_tx;
            end
            repeat (16) @(negedge clk);
            tx_stop  = usb_tx;
            tx_last  = tx_shift;
            tx_count++;
         end
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      compared++;
      assert (observed === expected) else begin
         mismatched++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Drive one 8N1 byte on usb_rx, then two bit-times of idle line.
   task automatic applyStimulus(input logic [7:0] value, input logic stop_bit);
      @(negedge clk);
      usb_rx = 1'b0;
      repeat (16) @(negedge clk);
      for (int b = 0; b < 8; b++) begin
         usb_rx = value[b];
         repeat (16) @(negedge clk);
      end
      usb_rx = stop_bit;
      repeat (16) @(negedge clk);
      usb_rx = 1'b1;
      repeat (32) @(negedge clk);
   endtask

   task automatic sendData(input int count);
      for (int k = 0; k < count; k++) applyStimulus(frame_data[k], 1'b1);
   endtask

   task automatic checkWrites(input string tag, input int first, input int count);
      for (int k = 0; k < count; k++) begin
         checkOutput($sformatf("%s_addr%0d", tag, k), 32'(wr_addr[first + k]), 32'(k));
         checkOutput($sformatf("%s_data%0d", tag, k), 32'(wr_data[first + k]),
                     32'(frame_data[k]));
      end
   endtask

   // Wait for a reply byte, compare it, and check cpu_hold drops right after it.
   task automatic checkReply(input string tag, input int tx_before,
                             input logic [7:0] expected);
      int n;
      n = 0;
      while (tx_count == tx_before && n < 600) begin
         @(negedge clk);
         n++;
      end
      checkOutput({tag, "_seen"}, 32'(tx_count - tx_before), 32'd1);
      checkOutput({tag, "_byte"}, 32'(tx_last), 32'(expected));
      checkOutput({tag, "_stop"}, 32'(tx_stop), 32'd1);
      checkOutput({tag, "_hold_in_stop"}, 32'(cpu_hold), 32'd1);
      n = 0;
      while (cpu_hold !== 1'b0 && n < 30) begin
         @(negedge clk);
         n++;
      end
      checkOutput({tag, "_hold_dropped"}, 32'(cpu_hold), 32'd0);
   endtask

   initial begin
      int wr0, tx0, ferr0, rxv0, n;
      compared   = 0;
      mismatched = 0;
      rst_n      = 1'b0;
      usb_rx     = 1'b1;
      repeat (5) @(negedge clk);
      checkOutput("reset_usb_tx", 32'(usb_tx), 32'd1);
      checkOutput("reset_prog_we", 32'(prog_we), 32'd0);
      checkOutput("reset_prog_addr", 32'(prog_addr), 32'd0);
      checkOutput("reset_prog_data", 32'(prog_data), 32'd0);
      checkOutput("reset_cpu_hold", 32'(cpu_hold), 32'd0);
      checkOutput("reset_load_done", 32'(load_done), 32'd0);
      checkOutput("reset_frame_err", 32'(frame_err), 32'd0);
      rst_n = 1'b1;
      repeat (20) @(negedge clk);

      $display("[TB] test 1: full frame 00..0F");
      for (int k = 0; k < 16; k++) frame_data[k] = 8'(k);
      wr0 = wr_count;
      tx0 = tx_count;
      applyStimulus(8'hA5, 1'b1);
      checkOutput("t1_hold_after_sync", 32'(cpu_hold), 32'd1);
      checkOutput("t1_no_write_for_sync", 32'(wr_count - wr0), 32'd0);
      sendData(16);
      checkOutput("t1_writes", 32'(wr_count - wr0), 32'd16);
      checkWrites("t1", wr0, 16);
      checkOutput("t1_load_done", 32'(load_done), 32'd1);
      checkReply("t1_ack", tx0, 8'h06);

      $display("[TB] test 2: junk bytes then frame with A5 inside data");
      for (int k = 0; k < 16; k++) frame_data[k] = 8'h20 + 8'(k);
      frame_data[3] = 8'hA5;
      wr0 = wr_count;
      tx0 = tx_count;
      applyStimulus(8'h3C, 1'b1);
      applyStimulus(8'h77, 1'b1);
      checkOutput("t2_no_write_junk", 32'(wr_count - wr0), 32'd0);
      checkOutput("t2_no_hold_junk", 32'(cpu_hold), 32'd0);
      checkOutput("t2_no_reply_junk", 32'(tx_count - tx0), 32'd0);
      applyStimulus(8'hA5, 1'b1);
      checkOutput("t2_load_done_cleared", 32'(load_done), 32'd0);
      sendData(16);
      checkOutput("t2_writes", 32'(wr_count - wr0), 32'd16);
      checkWrites("t2", wr0, 16);
      checkReply("t2_ack", tx0, 8'h06);

      $display("[TB] test 3: inter-byte timeout");
      for (int k = 0; k < 16; k++) frame_data[k] = 8'h40 + 8'(k);
      wr0   = wr_count;
      tx0   = tx_count;
      ferr0 = ferr_count;
      applyStimulus(8'hA5, 1'b1);
      sendData(5);
      n = 0;
      while (frame_err !== 1'b1 && n < 3000) begin
         @(negedge clk);
         n++;
      end
      checkOutput("t3_timeout_pulse", 32'(frame_err), 32'd1);
      checkOutput("t3_timeout_late_enough", 32'(n >= 1900), 32'd1);
      checkOutput("t3_timeout_not_too_late", 32'(n <= 2100), 32'd1);
      checkOutput("t3_writes", 32'(wr_count - wr0), 32'd5);
      checkWrites("t3", wr0, 5);
      checkReply("t3_nak", tx0, 8'h15);
      checkOutput("t3_load_done", 32'(load_done), 32'd0);
      checkOutput("t3_single_err", 32'(ferr_count - ferr0), 32'd1);

      $display("[TB] test 4: stop-bit error then good frame");
      for (int k = 0; k < 16; k++) frame_data[k] = 8'hFF - 8'(k);
      wr0   = wr_count;
      tx0   = tx_count;
      ferr0 = ferr_count;
      applyStimulus(8'hA5, 1'b1);
      sendData(2);
      applyStimulus(8'h99, 1'b0);
      checkOutput("t4_err_pulse", 32'(ferr_count - ferr0), 32'd1);
      checkOutput("t4_writes", 32'(wr_count - wr0), 32'd2);
      checkWrites("t4", wr0, 2);
      checkReply("t4_nak", tx0, 8'h15);
      checkOutput("t4_load_done", 32'(load_done), 32'd0);
      wr0 = wr_count;
      tx0 = tx_count;
      applyStimulus(8'hA5, 1'b1);
      sendData(16);
      checkOutput("t4_good_writes", 32'(wr_count - wr0), 32'd16);
      checkWrites("t4_good", wr0, 16);
      checkReply("t4_ack", tx0, 8'h06);
      checkOutput("t4_good_load_done", 32'(load_done), 32'd1);

      $display("[TB] test 5: 8-clock glitch while idle");
      wr0   = wr_count;
      ferr0 = ferr_count;
      rxv0  = rxv_count;
      @(negedge clk);
      usb_rx = 1'b0;
      repeat (8) @(negedge clk);
      usb_rx = 1'b1;
      repeat (400) @(negedge clk);
      checkOutput("t5_no_rx_valid", 32'(rxv_count - rxv0), 32'd0);
      checkOutput("t5_no_frame_err", 32'(ferr_count - ferr0), 32'd0);
      checkOutput("t5_no_writes", 32'(wr_count - wr0), 32'd0);
      checkOutput("t5_usb_tx", 32'(usb_tx), 32'd1);
      checkOutput("t5_cpu_hold", 32'(cpu_hold), 32'd0);
      checkOutput("t5_load_done", 32'(load_done), 32'd1);

      $display("[TB] test 6: reset mid-frame");
      for (int k = 0; k < 16; k++) frame_data[k] = 8'h80 + 8'(k);
      wr0 = wr_count;
      tx0 = tx_count;
      applyStimulus(8'hA5, 1'b1);
      sendData(7);
      checkOutput("t6_writes_before_reset", 32'(wr_count - wr0), 32'd7);
      checkOutput("t6_hold_before_reset", 32'(cpu_hold), 32'd1);
      rst_n = 1'b0;
      #1;
      checkOutput("t6_hold_at_reset", 32'(cpu_hold), 32'd0);
      checkOutput("t6_we_at_reset", 32'(prog_we), 32'd0);
      checkOutput("t6_tx_at_reset", 32'(usb_tx), 32'd1);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (300) @(negedge clk);
      checkOutput("t6_no_reply", 32'(tx_count - tx0), 32'd0);
      checkOutput("t6_hold_after_reset", 32'(cpu_hold), 32'd0);
      wr0 = wr_count;
      applyStimulus(8'hA5, 1'b1);
      sendData(16);
      checkOutput("t6_writes", 32'(wr_count - wr0), 32'd16);
      checkWrites("t6", wr0, 16);
      checkReply("t6_ack", tx0, 8'h06);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
